sm_debug_ctrl: RTL
==================

SM_DEBUG_CTRL -- requirements
Module: sm_debug_ctrl

Interface
REQ-001 Parameter BP_ENABLE, default 1; 0 removes breakpoint logic, and bp_hit is then tied 0.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_op  in  2  command: 00 RUN, 01 HALT, 10 STEP, 11 DUMP.
REQ-007 cmd_ready  out  1  command accept; a command is taken when cmd_valid and cmd_ready are both 1.
REQ-008 bp_en  in  1  breakpoint enable.
REQ-009 bp_addr  in  32  breakpoint instruction address, in word units like the core PC.
REQ-010 cpu_pc  in  32  core instruction memory address (current PC).
REQ-011 cpu_en  out  1  core clock enable; the core advances one instruction per cycle with cpu_en=1.
REQ-012 dbg_regAddr  out  5  core debug register address; address 0 returns the PC.
REQ-013 dbg_regData  in  32  core debug register data, combinational from dbg_regAddr.
REQ-014 dump_valid  out  1  dump beat valid.
REQ-015 dump_ready  in  1  dump beat accept.
REQ-016 dump_data  out  32  dump beat payload.
REQ-017 dump_last  out  1  marks the final dump beat.
REQ-018 halted  out  1  1 in the HALT and DUMP states.
REQ-019 bp_hit  out  1  sticky breakpoint flag; cleared by an accepted RUN or STEP.

Function
REQ-020 FSM states: HALT, RUN, STEP, DUMP; cpu_en = (RUN and not bp_stop) or STEP, combinational.
REQ-021 cmd_ready=1 in HALT and RUN, and 0 in STEP and DUMP.
REQ-022 HALT transitions: RUN->RUN, STEP->STEP, DUMP->DUMP, HALT->no-op, each taking effect on the next cycle.
REQ-023 RUN transitions: an accepted HALT gives cpu_en=1 in the accept cycle and HALT state next cycle; accepted RUN, STEP and DUMP are consumed with no effect.
REQ-024 Breakpoint: bp_stop = BP_ENABLE and bp_en and (cpu_pc==bp_addr) and state RUN and not resume.
REQ-025 On bp_stop: cpu_en=0 that cycle, next state HALT, bp_hit set to 1.
REQ-026 resume flag: set on entry to RUN and cleared after the first RUN cycle, so resuming from a breakpoint PC executes that instruction.
REQ-027 bp_stop and an accepted HALT in the same cycle: the breakpoint wins (cpu_en=0, bp_hit=1).
REQ-028 STEP lasts exactly 1 cycle with cpu_en=1, then HALT; breakpoints are ignored in STEP.
REQ-029 DUMP streams 32 beats: beat k carries dbg_regData at dbg_regAddr=k, for k=0..31 (beat 0 = PC).
REQ-030 On DUMP entry: dbg_regAddr=0; dump_data and dump_valid are loaded at the end of the first DUMP cycle.
REQ-031 Each beat handshake (valid and ready) loads the next beat on the same edge, so continuous ready gives 1 beat per cycle.
REQ-032 With valid=1 and ready=0, dump_data, dump_last and dbg_regAddr hold stable.
REQ-033 dump_last=1 only on beat 31; its handshake gives dump_valid=0, dbg_regAddr=0 and HALT on the next cycle.
REQ-034 cpu_en=0 throughout DUMP; cmd_valid is ignored until DUMP exits.
REQ-035 dbg_regAddr is 0 outside DUMP; the beat counter is 6 bits and never wraps past 31.

Reset
REQ-036 While rst_n=0 the outputs are: state HALT, cpu_en=0, cmd_ready=1, dbg_regAddr=0, dump_valid=0, dump_data=0, dump_last=0, halted=1, bp_hit=0, resume=0.
REQ-037 Reset asserted mid-RUN or mid-DUMP returns all outputs to the REQ-036 values immediately, without waiting for a clock edge; a partial dump is discarded.

Verification
REQ-038 Reset, then STEP: exactly one cycle with cpu_en=1, then halted=1; core PC 0->1.
REQ-039 bp_addr=5, bp_en=1, RUN from PC 0: cpu_en=1 for 5 cycles and 0 at PC 5; bp_hit=1, halted=1, PC stays 5.
REQ-040 After REQ-039, issue RUN: PC 5 executes on the first cycle, RUN continues, and bp_hit clears.
REQ-041 DUMP with dump_ready=1: 32 consecutive beats; beat 0 = PC, beat k = reg k; dump_last only on beat 31.
REQ-042 DUMP with dump_ready toggling every other cycle: no beat lost or duplicated, and data holds stable while stalled.
REQ-043 rst_n pulsed low during beat 10 of a DUMP: outputs immediately match REQ-036, and a new DUMP restarts at beat 0.

Source files
------------

// File: rtl/sm_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sm_debug_ctrl
// Purpose  : Debug controller for a single-issue core. It gates the core
//            clock enable (run / halt / single-step), stops the core on an
//            instruction-address breakpoint, and streams the 32 core debug
//            registers out as a ready/valid beat stream.
// Ports    : clk, rst_n               clock, async active-low reset
//            cmd_valid/cmd_op/cmd_ready  command channel (RUN/HALT/STEP/DUMP)
//            bp_en, bp_addr, cpu_pc   breakpoint compare inputs
//            cpu_en                   core clock enable
//            dbg_regAddr/dbg_regData  core debug register read port
//            dump_valid/ready/data/last  register dump stream
//            halted, bp_hit           status
// Revision : 1.0  initial release
// ============================================================================
module sm_debug_ctrl #(
  parameter int BP_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] cpu_pc,
  output logic        cpu_en,
  output logic [4:0]  dbg_regAddr,
  input  logic [31:0] dbg_regData,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        halted,
  output logic        bp_hit
);

  localparam logic [1:0] c_OP_RUN  = 2'b00;
  localparam logic [1:0] c_OP_HALT = 2'b01;
  localparam logic [1:0] c_OP_STEP = 2'b10;
  localparam logic [1:0] c_OP_DUMP = 2'b11;
  localparam logic [5:0] c_LAST_BEAT = 6'd31;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_resume;     // first RUN cycle: breakpoint at current PC is skipped
  logic        r_bpHit;
  logic        r_dumpValid;
  logic        r_dumpLast;
  logic [31:0] r_dumpData;
  logic [5:0]  r_beatCnt;    // index of the next register to fetch (0..32)

  logic w_cmdAccept;
  logic w_bpMatch;
  logic w_bpStop;

  generate
    if (BP_ENABLE != 0) begin : g_bp
      assign w_bpMatch = bp_en && (cpu_pc == bp_addr);
      assign bp_hit    = r_bpHit;
    end else begin : g_noBp
      assign w_bpMatch = 1'b0;
      assign bp_hit    = 1'b0;
    end
  endgenerate

  assign cmd_ready   = (r_state == S_HALT) || (r_state == S_RUN);
  assign w_cmdAccept = cmd_valid && cmd_ready;
  assign w_bpStop    = w_bpMatch && (r_state == S_RUN) && !r_resume;
  assign cpu_en      = ((r_state == S_RUN) && !w_bpStop) || (r_state == S_STEP);
  assign halted      = (r_state == S_HALT) || (r_state == S_DUMP);

  // The read address runs one beat ahead of dump_data so the next beat can be
  // captured on the same edge that retires the current one. After beat 31 is
  // fetched the counter sits at 32, whose low five bits read as register 0.
  assign dbg_regAddr = (r_state == S_DUMP) ? r_beatCnt[4:0] : 5'd0;
  assign dump_valid  = r_dumpValid;
  assign dump_data   = r_dumpData;
  assign dump_last   = r_dumpLast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HALT;
      r_resume    <= 1'b0;
      r_bpHit     <= 1'b0;
      r_dumpValid <= 1'b0;
      r_dumpLast  <= 1'b0;
      r_dumpData  <= 32'd0;
      r_beatCnt   <= 6'd0;
    end else begin
      case (r_state)
        S_HALT: begin
          if (w_cmdAccept) begin
            case (cmd_op)
              c_OP_RUN: begin
                r_state  <= S_RUN;
                r_resume <= 1'b1;
                r_bpHit  <= 1'b0;
              end
              c_OP_STEP: begin
                r_state <= S_STEP;
                r_bpHit <= 1'b0;
              end
              c_OP_DUMP: begin
                r_state     <= S_DUMP;
                r_beatCnt   <= 6'd0;
                r_dumpValid <= 1'b0;
                r_dumpLast  <= 1'b0;
              end
              default: ;  // HALT while halted is a no-op
            endcase
          end
        end

        S_RUN: begin
          r_resume <= 1'b0;
          // A breakpoint outranks a HALT command arriving in the same cycle.
          if (w_bpStop) begin
            r_state <= S_HALT;
            r_bpHit <= 1'b1;
          end else if (w_cmdAccept) begin
            if (cmd_op == c_OP_HALT) begin
              r_state <= S_HALT;
            end else if (cmd_op != c_OP_DUMP) begin
              r_bpHit <= 1'b0;
            end
          end
        end

        S_STEP: begin
          r_state <= S_HALT;
        end

        S_DUMP: begin
          if (!r_dumpValid || dump_ready) begin
            if (r_dumpLast) begin
              r_dumpValid <= 1'b0;
              r_dumpLast  <= 1'b0;
              r_beatCnt   <= 6'd0;
              r_state     <= S_HALT;
            end else begin
              r_dumpData  <= dbg_regData;
              r_dumpValid <= 1'b1;
              r_dumpLast  <= (r_beatCnt == c_LAST_BEAT);
              r_beatCnt   <= r_beatCnt + 6'd1;
            end
          end
        end

        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule
`default_nettype wire
